// File: rtl/audio_bank_ring.sv
// N-bank audio ring between the SD block writer and the sample reader; owns bank select and fill bookkeeping.
// Reads return RD_LATENCY cycles after request (ram_rd_data_i sampled RD_LATENCY-1 edges after the address); writes drop while full.
module audio_bank_ring #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   BANK_ADDR_BITS = 9,
  parameter int                   BANK_SEL_BITS  = 2,
  parameter int                   RD_LATENCY     = 2,
  parameter logic [DATA_BITS-1:0] SILENCE        = 8'h80,
  parameter int                   UNDERRUN_BITS  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush_i,
  input  logic [BANK_ADDR_BITS-1:0]               audio_buffer_addr_i,
  input  logic                                    audio_buffer_wren_i,
  input  logic [DATA_BITS-1:0]                    audio_buffer_data_i,
  input  logic                                    audio_buffer_filled_i,
  output logic                                    audio_buffer_empty_o,
  output logic [BANK_SEL_BITS+BANK_ADDR_BITS-1:0] ram_wr_address_o,
  output logic                                    ram_wren_o,
  output logic [DATA_BITS-1:0]                    ram_wr_data_o,
  output logic [BANK_SEL_BITS+BANK_ADDR_BITS-1:0] ram_rd_address_o,
  input  logic [DATA_BITS-1:0]                    ram_rd_data_i,
  input  logic                                    rd_req_i,
  output logic                                    rd_valid_o,
  output logic [DATA_BITS-1:0]                    rd_data_o,
  output logic [BANK_SEL_BITS:0]                  banks_full_o,
  output logic [UNDERRUN_BITS-1:0]                underrun_cnt_o,
  output logic                                    overflow_o
);

  localparam int NUM_BANKS = 1 << BANK_SEL_BITS;
  localparam logic [BANK_SEL_BITS:0]      C_FULL     = (BANK_SEL_BITS+1)'(NUM_BANKS);
  localparam logic [BANK_SEL_BITS:0]      C_CNT_ONE  = (BANK_SEL_BITS+1)'(1);
  localparam logic [BANK_SEL_BITS-1:0]    C_BANK_ONE = BANK_SEL_BITS'(1);
  localparam logic [BANK_ADDR_BITS-1:0]   C_OFF_ONE  = BANK_ADDR_BITS'(1);
  localparam logic [BANK_ADDR_BITS-1:0]   C_OFF_LAST = '1;
  localparam logic [UNDERRUN_BITS-1:0]    C_UND_ONE  = UNDERRUN_BITS'(1);

  logic [BANK_SEL_BITS-1:0]  r_wr_bank;
  logic [BANK_SEL_BITS-1:0]  r_rd_bank;
  logic [BANK_ADDR_BITS-1:0] r_rd_offset;
  logic [BANK_SEL_BITS:0]    r_count;
  logic                      r_empty;
  logic                      r_overflow;
  logic [UNDERRUN_BITS-1:0]  r_underrun_cnt;
  logic [RD_LATENCY-1:0]     r_vld_sr;
  logic [RD_LATENCY-1:0]     r_sil_sr;
  logic [DATA_BITS-1:0]      r_rd_data;

  logic                      w_full;
  logic                      w_commit;
  logic                      w_commit_over;
  logic                      w_rd_normal;
  logic                      w_rd_underrun;
  logic                      w_release;
  logic [BANK_SEL_BITS:0]    w_count_nxt;
  logic [RD_LATENCY-1:0]     w_vld_nxt;
  logic [RD_LATENCY-1:0]     w_sil_nxt;

  assign w_full        = (r_count == C_FULL);
  assign w_commit      = audio_buffer_filled_i & ~w_full;
  assign w_commit_over = audio_buffer_filled_i & w_full;
  // Underrun is judged on the pre-edge count, so a same-cycle commit still yields silence.
  assign w_rd_normal   = rd_req_i & (r_count != '0);
  assign w_rd_underrun = rd_req_i & (r_count == '0);
  assign w_release     = w_rd_normal & (r_rd_offset == C_OFF_LAST);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_commit, w_release})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Stage RD_LATENCY-1 of the next shift value is the request whose data lands in the output register.
  assign w_vld_nxt = (r_vld_sr << 1) | RD_LATENCY'(rd_req_i);
  assign w_sil_nxt = (r_sil_sr << 1) | RD_LATENCY'(w_rd_underrun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank      <= '0;
      r_rd_bank      <= '0;
      r_rd_offset    <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
      r_vld_sr       <= '0;
      r_sil_sr       <= '0;
      r_rd_data      <= SILENCE;
    end else if (flush_i) begin
      r_wr_bank      <= '0;
      r_rd_bank      <= '0;
      r_rd_offset    <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
      r_vld_sr       <= '0;
      r_sil_sr       <= '0;
      r_rd_data      <= SILENCE;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt != C_FULL);
      if (w_commit)
        r_wr_bank <= r_wr_bank + C_BANK_ONE;
      if (w_commit_over)
        r_overflow <= 1'b1;
      if (w_rd_normal) begin
        r_rd_offset <= r_rd_offset + C_OFF_ONE;
        if (w_release)
          r_rd_bank <= r_rd_bank + C_BANK_ONE;
      end
      if (w_rd_underrun && (r_underrun_cnt != '1))
        r_underrun_cnt <= r_underrun_cnt + C_UND_ONE;
      r_vld_sr <= w_vld_nxt;
      r_sil_sr <= w_sil_nxt;
      if (w_vld_nxt[RD_LATENCY-1])
        r_rd_data <= w_sil_nxt[RD_LATENCY-1] ? SILENCE : ram_rd_data_i;
    end
  end

  assign audio_buffer_empty_o = r_empty;
  assign ram_wr_address_o     = {r_wr_bank, audio_buffer_addr_i};
  assign ram_wren_o           = audio_buffer_wren_i & ~w_full;
  assign ram_wr_data_o        = audio_buffer_data_i;
  assign ram_rd_address_o     = {r_rd_bank, r_rd_offset};
  assign rd_valid_o           = r_vld_sr[RD_LATENCY-1];
  assign rd_data_o            = r_rd_data;
  assign banks_full_o         = r_count;
  assign underrun_cnt_o       = r_underrun_cnt;
  assign overflow_o           = r_overflow;

endmodule

// File: tb/tb_audio_bank_ring.sv
// Directed bench for audio_bank_ring with a synchronous RAM model and a read-data scoreboard.
module tb_audio_bank_ring;
  localparam int DB = 8;
  localparam int BA = 9;
  localparam int BS = 2;
  localparam int RL = 2;
  localparam int UB = 16;
  localparam int AW = BS + BA;
  localparam int NB = 4;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic [BA-1:0] audio_buffer_addr_i;
  logic          audio_buffer_wren_i;
  logic [DB-1:0] audio_buffer_data_i;
  logic          audio_buffer_filled_i;
  logic          audio_buffer_empty_o;
  logic [AW-1:0] ram_wr_address_o;
  logic          ram_wren_o;
  logic [DB-1:0] ram_wr_data_o;
  logic [AW-1:0] ram_rd_address_o;
  logic [DB-1:0] ram_rd_data_i;
  logic          rd_req_i;
  logic          rd_valid_o;
  logic [DB-1:0] rd_data_o;
  logic [BS:0]   banks_full_o;
  logic [UB-1:0] underrun_cnt_o;
  logic          overflow_o;

  audio_bank_ring #(
    .DATA_BITS(DB), .BANK_ADDR_BITS(BA), .BANK_SEL_BITS(BS),
    .RD_LATENCY(RL), .SILENCE(8'h80), .UNDERRUN_BITS(UB)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .audio_buffer_addr_i(audio_buffer_addr_i),
    .audio_buffer_wren_i(audio_buffer_wren_i),
    .audio_buffer_data_i(audio_buffer_data_i),
    .audio_buffer_filled_i(audio_buffer_filled_i),
    .audio_buffer_empty_o(audio_buffer_empty_o),
    .ram_wr_address_o(ram_wr_address_o),
    .ram_wren_o(ram_wren_o),
    .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_address_o(ram_rd_address_o),
    .ram_rd_data_i(ram_rd_data_i),
    .rd_req_i(rd_req_i),
    .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o),
    .banks_full_o(banks_full_o),
    .underrun_cnt_o(underrun_cnt_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle synchronous dual-port RAM.
  logic [DB-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren_o) mem[ram_wr_address_o] <= ram_wr_data_o;
    ram_rd_data_i <= mem[ram_rd_address_o];
  end

  int n_assert = 0;
  int n_fail = 0;

  logic [DB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DB-1:0] mon_e;
  int            mon_c;

  int m_count, m_rd_bank, m_rd_off, m_wr_bank, m_under;
  bit m_ovf;

  function automatic logic [7:0] pat(input int b, input int o);
    return 8'(o) + 8'(b * 53);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid_o) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed=1 expected=0 cycle=%0d", cyc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("rd_data", 32'(rd_data_o), 32'(mon_e));
        chk("rd_latency_cycle", cyc, mon_c);
      end
    end
  end

  task automatic model_reset();
    m_count = 0; m_rd_bank = 0; m_rd_off = 0; m_wr_bank = 0; m_under = 0; m_ovf = 0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic step(input bit req, input bit fill);
    bit rel, com;
    rd_req_i = req;
    audio_buffer_filled_i = fill;
    rel = 0;
    com = fill && (m_count < NB);
    if (fill && m_count == NB) m_ovf = 1;
    if (req) begin
      exp_cyc_q.push_back(cyc + RL);
      if (m_count == 0) begin
        exp_q.push_back(8'h80);
        if (m_under < 65535) m_under++;
      end else begin
        exp_q.push_back(pat(m_rd_bank, m_rd_off));
        rel = (m_rd_off == DEPTH - 1);
        m_rd_off = (m_rd_off + 1) % DEPTH;
        if (rel) m_rd_bank = (m_rd_bank + 1) % NB;
      end
    end
    if (com) m_wr_bank = (m_wr_bank + 1) % NB;
    m_count = m_count + int'(com) - int'(rel);
    @(posedge clk);
    #1;
    rd_req_i = 1'b0;
    audio_buffer_filled_i = 1'b0;
  endtask

  task automatic write_words();
    for (int o = 0; o < DEPTH; o++) begin
      audio_buffer_wren_i = 1'b1;
      audio_buffer_addr_i = BA'(o);
      audio_buffer_data_i = pat(m_wr_bank, o);
      if (o == 100) begin
        #1;
        chk("wr_gate_open", 32'(ram_wren_o), 32'(m_count < NB));
        chk("wr_address", 32'(ram_wr_address_o), 32'(m_wr_bank * DEPTH + o));
      end
      step(0, 0);
    end
    audio_buffer_wren_i = 1'b0;
  endtask

  task automatic write_bank();
    write_words();
    step(0, 1);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; rd_req_i = 1'b0;
    audio_buffer_addr_i = '0; audio_buffer_wren_i = 1'b0;
    audio_buffer_data_i = '0; audio_buffer_filled_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_empty", 32'(audio_buffer_empty_o), 32'd1);
    chk("rst_banks_full", 32'(banks_full_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_address_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'h80);

    // Reset asserted mid-stream with reads in flight.
    audio_buffer_wren_i = 1'b1; audio_buffer_addr_i = 9'd5; audio_buffer_data_i = 8'h5a;
    step(1, 0);
    step(1, 0);
    audio_buffer_wren_i = 1'b0;
    chk("pre_rst_underrun", 32'(underrun_cnt_o), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("async_rst_underrun", 32'(underrun_cnt_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(0, 0);
    chk("idle_empty", 32'(audio_buffer_empty_o), 32'd1);
    chk("idle_banks_full", 32'(banks_full_o), 32'd0);
    chk("idle_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("idle_rd_addr", 32'(ram_rd_address_o), 32'd0);

    // Underrun: three silence reads, pointers held.
    read_n(3);
    drain();
    chk("underrun_cnt", 32'(underrun_cnt_o), 32'(m_under));
    chk("underrun_cnt_3", 32'(underrun_cnt_o), 32'd3);
    chk("underrun_rd_addr", 32'(ram_rd_address_o), 32'd0);
    chk("underrun_banks", 32'(banks_full_o), 32'd0);

    // Fill bank 0 and read it back.
    write_bank();
    chk("commit_banks_full", 32'(banks_full_o), 32'd1);
    chk("commit_wr_bank", 32'(ram_wr_address_o[AW-1:BA]), 32'd1);
    chk("commit_empty", 32'(audio_buffer_empty_o), 32'd1);
    read_n(DEPTH - 1);
    chk("pre_release_banks", 32'(banks_full_o), 32'd1);
    step(1, 0);
    chk("release_banks", 32'(banks_full_o), 32'd0);
    chk("release_rd_addr", 32'(ram_rd_address_o), 32'(1 * DEPTH));
    drain();

    // Fill the whole ring, then try to overfill.
    repeat (NB) write_bank();
    chk("full_banks", 32'(banks_full_o), 32'd4);
    chk("full_empty", 32'(audio_buffer_empty_o), 32'd0);
    audio_buffer_wren_i = 1'b1; audio_buffer_addr_i = 9'd3; audio_buffer_data_i = 8'h77;
    #1;
    chk("full_wren_gated", 32'(ram_wren_o), 32'd0);
    step(0, 1);
    audio_buffer_wren_i = 1'b0;
    chk("overflow_set", 32'(overflow_o), 32'(m_ovf));
    chk("overflow_banks", 32'(banks_full_o), 32'd4);
    chk("overflow_wr_bank", 32'(ram_wr_address_o[AW-1:BA]), 32'd1);

    // Commit and release on the same edge at count 2.
    read_n(2 * DEPTH);
    chk("two_left", 32'(banks_full_o), 32'd2);
    write_words();
    read_n(DEPTH - 1);
    step(1, 1);
    chk("simul_banks", 32'(banks_full_o), 32'd2);
    chk("simul_rd_addr", 32'(ram_rd_address_o), 32'd0);
    chk("simul_wr_bank", 32'(ram_wr_address_o[AW-1:BA]), 32'd2);
    drain();

    // Flush with reads in flight.
    write_bank();
    chk("preflush_banks", 32'(banks_full_o), 32'd3);
    step(1, 0);
    step(1, 0);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    model_reset();
    chk("flush_banks", 32'(banks_full_o), 32'd0);
    chk("flush_overflow", 32'(overflow_o), 32'd0);
    chk("flush_underrun", 32'(underrun_cnt_o), 32'd0);
    chk("flush_empty", 32'(audio_buffer_empty_o), 32'd1);
    chk("flush_rd_addr", 32'(ram_rd_address_o), 32'd0);
    chk("flush_rd_valid", 32'(rd_valid_o), 32'd0);
    repeat (4) step(0, 0);
    chk("flush_rd_data", 32'(rd_data_o), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_bank_ring.md
Name: audio_bank_ring

Overview:
- Parametrised N-bank audio ring buffer controller; successor to the fixed two-bank (ping-pong) scheme in the sound player top level.
- Sits between FAT32_reader (writer, one SD block per bank) and the audio output path (reader, one sample per request).
- Owns the RAM_dualport address MSBs (bank select) and all bank bookkeeping.
- Adds underrun detection with silence fill, overflow flagging, flush, and a fill-level output.

Parameters:
- DATA_BITS, 8: width of the RAM data word.
- BANK_ADDR_BITS, 9: offset bits per bank; bank depth is 2**BANK_ADDR_BITS words (512 = one SD block).
- BANK_SEL_BITS, 2: bank-select bits; NUM_BANKS = 2**BANK_SEL_BITS. Legal range 1..4.
- RD_LATENCY, 2: cycles from an accepted read request to RAM data valid. Legal range 1..4.
- SILENCE, 8'h80: word returned on underrun (unsigned 8-bit PCM midpoint).
- UNDERRUN_BITS, 16: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock (200 MHz main PLL output).
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all banks and pointers.
- audio_buffer_addr_i  in  BANK_ADDR_BITS  writer offset within the current write bank.
- audio_buffer_wren_i  in  1  writer write strobe.
- audio_buffer_data_i  in  DATA_BITS  writer data.
- audio_buffer_filled_i  in  1  one-cycle pulse: commit the current write bank.
- audio_buffer_empty_o  out  1  high while at least one free bank exists.
- ram_wr_address_o  out  BANK_SEL_BITS+BANK_ADDR_BITS  {wr_bank, audio_buffer_addr_i}.
- ram_wren_o  out  1  gated RAM write enable.
- ram_wr_data_o  out  DATA_BITS  audio_buffer_data_i passed through.
- ram_rd_address_o  out  BANK_SEL_BITS+BANK_ADDR_BITS  {rd_bank, rd_offset}.
- ram_rd_data_i  in  DATA_BITS  RAM read data.
- rd_req_i  in  1  reader requests the next sample; at most one request per cycle.
- rd_valid_o  out  1  one-cycle pulse: rd_data_o is valid.
- rd_data_o  out  DATA_BITS  sample, or SILENCE on underrun.
- banks_full_o  out  BANK_SEL_BITS+1  number of committed, unread banks (0..NUM_BANKS).
- underrun_cnt_o  out  UNDERRUN_BITS  saturating count of underrun reads.
- overflow_o  out  1  sticky flag: commit attempted while the ring was full.

Behaviour:
- Reset (rst high, asynchronous): wr_bank, rd_bank, rd_offset and count are 0.
  - audio_buffer_empty_o is 1; rd_valid_o, overflow_o, underrun_cnt_o and banks_full_o are 0.
  - rd_data_o is SILENCE; the valid pipeline is cleared.
- flush_i has the same effect as reset, applied at the clock edge. It has priority over all other events in that cycle.
- full = (count == NUM_BANKS).
  - audio_buffer_empty_o = !full (registered from count).
  - banks_full_o = count.
- Write path is combinational: ram_wren_o = audio_buffer_wren_i & !full. Writes while full are silently dropped.
- Commit (audio_buffer_filled_i while !full): wr_bank <= wr_bank+1 (mod NUM_BANKS), count+1.
- Commit while full: ignored, and overflow_o <= 1. overflow_o clears only on rst or flush_i.
- Read acceptance: rd_req_i is always accepted.
  - Normal read (count > 0): ram_rd_address_o presents the current {rd_bank, rd_offset}. rd_offset <= rd_offset+1.
  - Release: when rd_offset == 2**BANK_ADDR_BITS-1, rd_offset wraps to 0, rd_bank <= rd_bank+1 and count-1 on the same edge.
  - Underrun read (count == 0): pointers are unchanged; underrun_cnt_o increments, saturating at all-ones. The request is tagged as silence.
- Read pipeline: a RD_LATENCY-deep shift register carries {valid, silence_tag}.
  - rd_valid_o asserts exactly RD_LATENCY cycles after an accepted rd_req_i.
  - rd_data_o = silence_tag ? SILENCE : ram_rd_data_i, registered together with rd_valid_o.
  - Back-to-back requests yield back-to-back valids.
- Simultaneous commit and release in the same cycle: count is unchanged and both pointers advance.
- Simultaneous commit and underrun: the underrun is decided on the pre-edge count, so silence is returned. count becomes 1.
- Commit at count = NUM_BANKS-1 makes full = 1 on the next cycle; ram_wren_o is gated from that cycle.
- Pointer wrap: wr_bank and rd_bank wrap naturally at BANK_SEL_BITS. rd_bank never passes wr_bank because count guards it.

Test Plan:
- Reset / idle: assert rst mid-stream, then release with no activity -> audio_buffer_empty_o=1, banks_full_o=0, rd_valid_o=0, ram_rd_address_o=0.
- Fill and commit: write 512 bytes with data = addr[7:0] into bank 0, pulse filled -> banks_full_o=1, ram_wr_address_o MSBs = 1. Then 512 rd_req_i -> data 0..255 twice, each rd_valid_o exactly 2 cycles after its request. banks_full_o returns to 0 on the 512th accepted request.
- Full ring: commit 4 banks -> audio_buffer_empty_o=0, ram_wren_o=0 despite wren_i=1. A 5th filled pulse sets overflow_o=1, and banks_full_o stays 4.
- Underrun: 3 rd_req_i with count=0 -> three rd_valid_o pulses with rd_data_o=8'h80, underrun_cnt_o=3. Pointers are unchanged.
- Simultaneous events: with count=2, pulse filled on the same cycle as the 512th read of a bank -> count stays 2, and wr_bank and rd_bank each advance by 1.
- Flush: with count=3 and reads in flight, pulse flush_i -> next cycle count=0, overflow_o=0, underrun_cnt_o=0, no rd_valid_o pulses from the flushed requests.
